// File: rtl/pipelined_array_multiplier.sv
// Three-stage WIDTH x WIDTH multiplier: operand regs, Baugh-Wooley carry-save array, Sklansky prefix adder.
// Optional narrow-overflow flag out_ovf is built when MULT_NARROW_OVF_EN is defined.
module pipelined_array_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
`ifdef MULT_NARROW_OVF_EN
  ,
  output logic                 out_ovf
`endif
);

  localparam int PW  = 2 * WIDTH;
  localparam int LVL = $clog2(PW);

  logic             v1_q, v2_q, v3_q;
  logic             r1, r2, r3;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [PW-1:0]    rowa_q, rowb_q, rowa_d, rowb_d;
  logic [PW-1:0]    prod_q, sum_d;

  assign r3        = !v3_q | out_ready;
  assign r2        = !v2_q | r3;
  assign r1        = !v1_q | r2;
  assign in_ready  = r1;
  assign out_valid = v3_q;
  assign out_product = prod_q;

  // Data registers only load from a valid source, so don't-care inputs never enter the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
    end else if (r1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b;
        sgn_q <= in_signed;
      end
    end
  end

  // Linear carry-save array: each row is folded in with a 3:2 compressor, carries only shift left.
  // Signed mode inverts the cross terms with exactly one sign bit and adds 1 at bits WIDTH and PW-1.
  always_comb begin : csa_array
    logic [PW-1:0] s, c, row, t;
    s = '0;
    s[WIDTH] = sgn_q;
    s[PW-1]  = sgn_q;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = '0;
      for (int j = 0; j < WIDTH; j++)
        row[i+j] = (a_q[j] & b_q[i]) ^ (sgn_q & ((i == WIDTH-1) != (j == WIDTH-1)));
      t = s ^ c ^ row;
      c = ((s & c) | (s & row) | (c & row)) << 1;
      s = t;
    end
    rowa_d = s;
    rowb_d = c;
  end

`ifdef MULT_NARROW_OVF_EN
  logic sgn2_q, ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      rowa_q <= '0;
      rowb_q <= '0;
`ifdef MULT_NARROW_OVF_EN
      sgn2_q <= 1'b0;
`endif
    end else if (r2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        rowa_q <= rowa_d;
        rowb_q <= rowb_d;
`ifdef MULT_NARROW_OVF_EN
        sgn2_q <= sgn_q;
`endif
      end
    end
  end

  // Sklansky prefix tree. Cells whose group reaches bit 0 are GREY (generate only), others BLACK.
  always_comb begin : prefix_add
    logic [PW-1:0] g, p, gn, pn, hp;
    int j;
    g  = rowa_q & rowb_q;
    p  = rowa_q ^ rowb_q;
    hp = p;
    for (int l = 0; l < LVL; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < PW; i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> l) << l) - 1;
          gn[i] = g[i] | (p[i] & g[j]);
          if ((i >> (l + 1)) != 0) pn[i] = p[i] & p[j];
        end
      end
      g = gn;
      p = pn;
    end
    sum_d = hp ^ {g[PW-2:0], 1'b0};
  end

`ifdef MULT_NARROW_OVF_EN
  always_comb begin
    if (sgn2_q) ovf_d = !((&sum_d[PW-1:WIDTH-1]) | ~(|sum_d[PW-1:WIDTH-1]));
    else        ovf_d = |sum_d[PW-1:WIDTH];
  end
  assign out_ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q   <= 1'b0;
      prod_q <= '0;
`ifdef MULT_NARROW_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (r3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        prod_q <= sum_d;
`ifdef MULT_NARROW_OVF_EN
        ovf_q  <= ovf_d;
`endif
      end
    end
  end

endmodule
